// File: rtl/reg_cmd_ctrl_if.sv
// UART byte and register file signals seen by the command sequencer.
// The master modport is the sequencer side; slave is the environment side.
interface reg_cmd_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] reg_data_in;
  logic       reg_read;
  logic       reg_write;
  logic [7:0] reg_data_out;
  logic       reg_valid;

  modport master (
    input  rx_data, rx_valid, tx_busy,
    input  reg_data_out, reg_valid,
    output tx_data, tx_start,
    output reg_data_in, reg_read, reg_write
  );

  modport slave (
    output rx_data, rx_valid, tx_busy,
    output reg_data_out, reg_valid,
    input  tx_data, tx_start,
    input  reg_data_in, reg_read, reg_write
  );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// Command sequencer: parses UART command bytes, runs one register file
// read or write handshake at a time and answers with data, ACK or NAK.
module reg_cmd_ctrl #(
  parameter int         NREGS   = 15,
  parameter int         TIMEOUT = 1000,
  parameter logic [7:0] ACK     = 8'hAA,
  parameter logic [7:0] NAK     = 8'hEE
) (
  input  logic          clk,
  input  logic          nRst,
  reg_cmd_ctrl_if.master bus,
  output logic          busy,
  output logic          overrun
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE,
    RD_REQ,
    RD_REL,
    WR_REQ,
    WR_DATA,
    WR_REL,
    TX,
    TX_WAIT,
    TX_DRAIN
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] timer;
  logic [7:0]    cap;
  logic [7:0]    cap_nx;
  logic [7:0]    din;
  logic [7:0]    din_nx;
  logic [7:0]    txd;
  logic [7:0]    txd_nx;
  logic          armed;
  logic          hs_ok;
  logic          counting;
  logic          expired;
  logic          cmd_bad;
  logic [3:0]    cmd_addr;

  assign cmd_addr = bus.rx_data[3:0];
  assign cmd_bad  = (bus.rx_data[6:4] != 3'b000)
                 || (int'(cmd_addr) >= NREGS);

  assign counting = state inside {RD_REQ, RD_REL, WR_REQ,
                                  WR_DATA, WR_REL};
  assign expired  = (timer == TW'(TIMEOUT - 1));

  // A request may only be raised once reg_valid has been seen low.
  assign hs_ok    = armed | ~bus.reg_valid;

  assign busy        = (state != IDLE);
  assign bus.tx_data = txd;

  always_comb begin
    state_nx        = state;
    cap_nx          = cap;
    din_nx          = din;
    txd_nx          = txd;
    bus.reg_read    = 1'b0;
    bus.reg_write   = 1'b0;
    bus.tx_start    = 1'b0;
    bus.reg_data_in = din;
    unique case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          if (cmd_bad) begin
            txd_nx   = NAK;
            state_nx = TX;
          end else begin
            din_nx   = {4'h0, cmd_addr};
            state_nx = bus.rx_data[7] ? WR_REQ : RD_REQ;
          end
        end
      end
      RD_REQ: begin
        bus.reg_read = hs_ok;
        if (hs_ok && bus.reg_valid) begin
          cap_nx   = bus.reg_data_out;
          state_nx = RD_REL;
        end else if (expired) begin
          txd_nx   = NAK;
          state_nx = TX;
        end
      end
      RD_REL: begin
        if (!bus.reg_valid) begin
          txd_nx   = cap;
          state_nx = TX;
        end else if (expired) begin
          txd_nx   = NAK;
          state_nx = TX;
        end
      end
      WR_REQ: begin
        bus.reg_write = hs_ok;
        if (hs_ok && bus.reg_valid) begin
          state_nx = WR_DATA;
        end else if (expired) begin
          txd_nx   = NAK;
          state_nx = TX;
        end
      end
      WR_DATA: begin
        // Data byte and the falling write share one cycle.
        if (bus.rx_valid) begin
          bus.reg_data_in = bus.rx_data;
          din_nx          = bus.rx_data;
          state_nx        = WR_REL;
        end else begin
          bus.reg_write = 1'b1;
          if (expired) begin
            txd_nx   = NAK;
            state_nx = TX;
          end
        end
      end
      WR_REL: begin
        if (!bus.reg_valid) begin
          txd_nx   = ACK;
          state_nx = TX;
        end else if (expired) begin
          txd_nx   = NAK;
          state_nx = TX;
        end
      end
      TX: begin
        if (!bus.tx_busy) begin
          bus.tx_start = 1'b1;
          state_nx     = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (bus.tx_busy) state_nx = TX_DRAIN;
      end
      TX_DRAIN: begin
        if (!bus.tx_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state   <= IDLE;
      timer   <= '0;
      cap     <= '0;
      din     <= '0;
      txd     <= '0;
      armed   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      cap   <= cap_nx;
      din   <= din_nx;
      txd   <= txd_nx;
      if (state_nx != state || !counting) timer <= '0;
      else timer <= timer + TW'(1);
      armed <= ~bus.reg_valid
            | (armed & ~(counting & (state_nx == TX)));
      if (bus.rx_valid && !(state == IDLE || state == WR_DATA))
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Randomized bench for reg_cmd_ctrl with a register file and UART model
// and a transaction-level reference of the expected reply bytes.
module tb_reg_cmd_ctrl;

  localparam int         NREGS   = 15;
  localparam int         TIMEOUT = 1000;
  localparam logic [7:0] ACK     = 8'hAA;
  localparam logic [7:0] NAK     = 8'hEE;

  logic clk = 1'b0;
  logic nRst;
  logic busy;
  logic overrun;

  reg_cmd_ctrl_if bus();

  reg_cmd_ctrl #(
    .NREGS(NREGS), .TIMEOUT(TIMEOUT), .ACK(ACK), .NAK(NAK)
  ) dut (
    .clk(clk), .nRst(nRst), .bus(bus),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  bit         exp_c[$];
  logic [7:0] ref_mem[16];
  bit         known[16];
  logic [7:0] exp_addr = 8'h00;
  bit         forbid = 1'b0;
  bit         exp_ovr = 1'b0;
  int         tx_count = 0;
  int         wr_hi = 0;
  logic [7:0] last_tx = 8'h00;
  logic [7:0] hold = 8'h00;

  logic [7:0] rf_mem[16];
  logic [7:0] rf_waddr = 8'h00;
  logic [7:0] rf_wdata = 8'h00;

  function automatic void chk(string name, logic [7:0] act,
                              logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h want %02h at %0t",
               name, act, exp, $time);
    end
  endfunction

  // Register file: answers a request in a random number of cycles,
  // drops reg_valid once the request is gone, latches write data then.
  initial begin
    logic rd, wr, rst;
    logic [7:0] d;
    bit wpend;
    for (int i = 0; i < 16; i++) rf_mem[i] = 8'(i * 37 + 11);
    wpend = 1'b0;
    bus.reg_valid = 1'b0;
    bus.reg_data_out = 8'h00;
    forever begin
      @(negedge clk);
      rd = bus.reg_read;
      wr = bus.reg_write;
      d = bus.reg_data_in;
      rst = nRst;
      @(posedge clk);
      #1;
      if ((rd || wr) && !bus.reg_valid) begin
        if ($urandom_range(0, 1) == 1) begin
          bus.reg_valid = 1'b1;
          if (rd) bus.reg_data_out = rf_mem[d[3:0]];
          if (wr) begin
            wpend = 1'b1;
            rf_waddr = d;
          end
        end
      end else if (!rd && !wr && bus.reg_valid) begin
        bus.reg_valid = 1'b0;
        if (wpend && rst) begin
          rf_mem[rf_waddr[3:0]] = d;
          rf_wdata = d;
        end
        wpend = 1'b0;
      end
    end
  end

  // UART transmitter: busy from the cycle after tx_start for 1..4 cycles.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start) begin
        @(posedge clk);
        #1 bus.tx_busy = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 bus.tx_busy = 1'b0;
      end
    end
  end

  task automatic monitor();
    logic [7:0] e;
    bit c;
    forever begin
      @(negedge clk);
      if (nRst) begin
        chk("rd_wr_excl", 8'(bus.reg_read & bus.reg_write), 8'h00);
        if (bus.reg_write) wr_hi++;
        if (bus.reg_read || bus.reg_write) begin
          if (forbid) chk("rf_touched", 8'h01, 8'h00);
          else chk("rf_addr", bus.reg_data_in, exp_addr);
        end
        chk("overrun", 8'(overrun), 8'(exp_ovr));
        if (bus.tx_start) begin
          tx_count++;
          if (exp_q.size() == 0) begin
            chk("tx_unexpected", bus.tx_data, 8'h00);
          end else begin
            e = exp_q.pop_front();
            c = exp_c.pop_front();
            if (c) chk("tx_data", bus.tx_data, e);
          end
          last_tx = bus.tx_data;
          hold = bus.tx_data;
        end
        if (bus.tx_busy) chk("tx_hold", bus.tx_data, hold);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_ack();
    int n = 0;
    while (!bus.reg_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.reg_valid) chk("ack_wait", 8'h00, 8'h01);
  endtask

  task automatic run_cmd(input logic [7:0] cmd, input logic [7:0] data,
                         input bit send_data, input bit inject);
    logic [3:0] a;
    bit good;
    int n;
    int t0;
    a = cmd[3:0];
    good = (cmd[6:4] == 3'b000) && (int'(a) < NREGS);
    forbid = !good;
    exp_addr = {4'h0, a};
    if (!good) begin
      exp_q.push_back(NAK); exp_c.push_back(1'b1);
    end else if (cmd[7]) begin
      if (send_data) begin
        exp_q.push_back(ACK); exp_c.push_back(1'b1);
        ref_mem[a] = data;
        known[a] = 1'b1;
      end else begin
        exp_q.push_back(NAK); exp_c.push_back(1'b1);
        known[a] = 1'b0;
      end
    end else begin
      exp_q.push_back(ref_mem[a]); exp_c.push_back(known[a]);
    end
    t0 = tx_count;
    send_byte(cmd);
    if (good && cmd[7] && send_data) begin
      wait_ack();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send_byte(data);
    end
    n = 0;
    while (tx_count == t0 && n < TIMEOUT + 300) begin
      @(negedge clk);
      n++;
    end
    if (tx_count == t0) chk("tx_wait", 8'h00, 8'h01);
    n = 0;
    while (!bus.tx_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (inject) begin
      send_byte(8'($urandom));
      exp_ovr = 1'b1;
    end else begin
      n = 0;
      while (bus.tx_busy && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("busy_hold", 8'(busy), 8'h01);
      @(negedge clk);
      chk("busy_idle", 8'(busy), 8'h00);
    end
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle", 8'(busy), 8'h00);
    forbid = 1'b0;
  endtask

  initial begin
    logic [7:0] cmd;
    int r;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'(i * 37 + 11);
      known[i] = 1'b1;
    end
    nRst = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_tx_start", 8'(bus.tx_start), 8'h00);
    chk("rst_din", bus.reg_data_in, 8'h00);
    chk("rst_read", 8'(bus.reg_read), 8'h00);
    chk("rst_write", 8'(bus.reg_write), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_overrun", 8'(overrun), 8'h00);
    nRst = 1'b1;

    run_cmd(8'h83, 8'h5A, 1'b1, 1'b0);
    chk("w83_addr", rf_waddr, 8'h03);
    chk("w83_data", rf_wdata, 8'h5A);
    chk("w83_ack", last_tx, 8'hAA);
    run_cmd(8'h03, 8'h00, 1'b0, 1'b0);
    chk("r03_data", last_tx, 8'h5A);
    run_cmd(8'h0F, 8'h00, 1'b0, 1'b0);
    chk("bad_addr", last_tx, 8'hEE);
    run_cmd(8'h13, 8'h00, 1'b0, 1'b0);
    chk("bad_bits", last_tx, 8'hEE);

    wr_hi = 0;
    run_cmd(8'h81, 8'h00, 1'b0, 1'b0);
    chk("to_nak", last_tx, 8'hEE);
    chk("to_len", 8'(wr_hi >= TIMEOUT + 1 && wr_hi <= TIMEOUT + 20),
        8'h01);

    run_cmd(8'h04, 8'h00, 1'b0, 1'b1);
    chk("ovr_set", 8'(overrun), 8'h01);
    run_cmd(8'h84, 8'h39, 1'b1, 1'b0);
    run_cmd(8'h04, 8'h00, 1'b0, 1'b0);
    chk("after_ovr", last_tx, 8'h39);

    run_cmd(8'h82, 8'hC3, 1'b1, 1'b0);
    exp_addr = 8'h02;
    send_byte(8'h82);
    wait_ack();
    @(posedge clk);
    #1;
    chk("wr_data_phase", 8'(bus.reg_write), 8'h01);
    #1 nRst = 1'b0;
    #1;
    chk("mid_rst_write", 8'(bus.reg_write), 8'h00);
    chk("mid_rst_read", 8'(bus.reg_read), 8'h00);
    chk("mid_rst_din", bus.reg_data_in, 8'h00);
    chk("mid_rst_txd", bus.tx_data, 8'h00);
    chk("mid_rst_busy", 8'(busy), 8'h00);
    chk("mid_rst_ovr", 8'(overrun), 8'h00);
    exp_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1 nRst = 1'b1;
    run_cmd(8'h02, 8'h00, 1'b0, 1'b0);
    chk("rst_keep", last_tx, 8'hC3);

    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) cmd = {4'h0, 4'($urandom_range(0, NREGS - 1))};
      else if (r < 8) cmd = {4'h8, 4'($urandom_range(0, NREGS - 1))};
      else cmd = 8'($urandom);
      run_cmd(cmd, 8'($urandom), 1'b1, $urandom_range(0, 7) == 0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("tx_missing", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
